aes_key_expander: RTL and testbench

Iterative AES-128 key schedule engine that sits directly upstream of the AES round datapath (the stage that applies sub-bytes, shift-rows, mix-columns and add-round-key). It accepts one 128-bit cipher key, then streams the 11 round keys (round 0 … round 10) in order, one per accepted handshake. It computes one key-expansion step per cycle and stores only the current round key.

---
 rtl/aes_key_expander_pkg.sv | 37 +++
 rtl/aes_key_g_func.sv | 27 ++
 rtl/aes_key_expander.sv | 82 ++++++++
 tb/tb_aes_key_expander.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expander_pkg.sv
// Shared AES-128 constants and types: S-box, round constants and the
// key-expander state encoding.
package aes_model_pack;

  localparam int DATA_WIDTH_IN_BYTES = 16;

  typedef enum logic {
    IDLE,
    STREAM
  } key_exp_state_t;

  localparam logic [7:0] SUB_BYTES_TABLE [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon sits in the top byte of the word; entry r-1 is used for round r.
  localparam logic [31:0] RCON_TABLE [0:9] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

endpackage

// File: rtl/aes_key_g_func.sv
// Key-schedule g function: SubWord(RotWord(word)) ^ Rcon[round-1].
module aes_key_g_func
  import aes_model_pack::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  round,
  output logic [31:0] g
);

  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] rcon;

  always_comb begin
    rot_word = {word[23:0], word[31:24]};
    sub_word = {SUB_BYTES_TABLE[rot_word[31:24]], SUB_BYTES_TABLE[rot_word[23:16]],
                SUB_BYTES_TABLE[rot_word[15:8]],  SUB_BYTES_TABLE[rot_word[7:0]]};
    // NOTE: default first so every path assigns rcon and no latch is inferred.
    rcon = '0;
    if (round >= 4'd1 && round <= 4'd10) begin
      rcon = RCON_TABLE[round - 4'd1];
    end
  end

  assign g = sub_word ^ rcon;

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: accepts one cipher key and streams round
// keys 0..10, one expansion step per accepted handshake.
module aes_key_expander #(
  parameter int DATA_WIDTH_IN_BYTES = aes_model_pack::DATA_WIDTH_IN_BYTES,
  parameter int NUM_ROUNDS          = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] key_in,
  input  logic                             key_valid,
  output logic                             key_ready,
  output logic [8*DATA_WIDTH_IN_BYTES-1:0] round_key,
  output logic                             round_key_valid,
  input  logic                             round_key_ready,
  output logic [3:0]                       round_idx,
  output logic                             last_key
);

  import aes_model_pack::*;

  localparam int         KEY_W    = 8 * DATA_WIDTH_IN_BYTES;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  key_exp_state_t   state;
  logic [KEY_W-1:0] key_q;
  logic [3:0]       idx_q;
  logic [3:0]       next_idx;
  logic [31:0]      g;
  logic [31:0]      n0, n1, n2, n3;

  assign next_idx = idx_q + 4'd1;

  aes_key_g_func u_g_func (
    .word  (key_q[31:0]),
    .round (next_idx),
    .g     (g)
  );

  // Each new word chains off the previous new word, so the XORs ripple w0 -> w3.
  assign n0 = key_q[KEY_W-1 -: 32] ^ g;
  assign n1 = key_q[KEY_W-33 -: 32] ^ n0;
  assign n2 = key_q[KEY_W-65 -: 32] ^ n1;
  assign n3 = key_q[31:0] ^ n2;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            key_q <= key_in;
            idx_q <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (round_key_ready) begin
            if (idx_q == LAST_IDX) begin
              state <= IDLE;
            end else begin
              key_q <= {n0, n1, n2, n3};
              idx_q <= next_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags are decodes of the state register only.
  assign key_ready       = (state == IDLE);
  assign round_key_valid = (state == STREAM);
  assign last_key        = (state == STREAM) && (idx_q == LAST_IDX);
  assign round_key       = key_q;
  assign round_idx       = idx_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 and hand-derived
// round-key vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic         round_key_ready;
  logic [3:0]   round_idx;
  logic         last_key;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_keys [0:10];
  bit           known    [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_expander dut (
    .clk             (clk),
    .rst             (rst),
    .key_in          (key_in),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .round_key       (round_key),
    .round_key_valid (round_key_valid),
    .round_key_ready (round_key_ready),
    .round_idx       (round_idx),
    .last_key        (last_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fips();
    for (int i = 0; i <= 10; i++) begin
      exp_keys[i] = FIPS_RK[i];
      known[i]    = 1'b1;
    end
  endtask

  task automatic set_partial(input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k10,
                             input bit k10_known);
    for (int i = 0; i <= 10; i++) begin
      exp_keys[i] = '0;
      known[i]    = 1'b0;
    end
    exp_keys[0]  = k0;  known[0]  = 1'b1;
    exp_keys[1]  = k1;  known[1]  = 1'b1;
    exp_keys[10] = k10; known[10] = k10_known;
  endtask

  task automatic load_key(input logic [127:0] k);
    check("load key_ready", key_ready, 1);
    key_in          = k;
    key_valid       = 1'b1;
    round_key_ready = 1'b0;
    step();
    key_valid = 1'b0;
  endtask

  // Walks the stream comparing every cycle against exp_keys; inject_at pulses
  // key_valid with an all-ff key while that round is on the output.
  task automatic run_stream(input bit stall, input int inject_at);
    int got = 0;
    int cyc = 0;
    bit rdy;
    while (got <= 10 && cyc < 300) begin
      check($sformatf("valid r%0d", got), round_key_valid, 1);
      check($sformatf("key_ready r%0d", got), key_ready, 0);
      check($sformatf("idx r%0d", got), round_idx, got);
      if (known[got]) check($sformatf("key r%0d", got), round_key, exp_keys[got]);
      check($sformatf("last r%0d", got), last_key, (got == 10));
      if (got == inject_at) begin
        key_valid = 1'b1;
        key_in    = '1;
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      round_key_ready = rdy;
      step();
      key_valid = 1'b0;
      if (rdy) got++;
      cyc++;
    end
    round_key_ready = 1'b0;
    check("stream bound", cyc < 300, 1);
    if (!stall) check("stream cycles", cyc, 11);
    check("end key_ready", key_ready, 1);
    check("end valid", round_key_valid, 0);
    check("end last", last_key, 0);
  endtask

  initial begin
    rst             = 1'b1;
    key_in          = '0;
    key_valid       = 1'b0;
    round_key_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst key_ready", key_ready, 1);
    check("rst valid", round_key_valid, 0);
    check("rst round_key", round_key, 0);
    check("rst idx", round_idx, 0);
    check("rst last", last_key, 0);

    // FIPS key, ready held high, with an all-ff key pulsed during round 3.
    set_fips();
    load_key(FIPS_KEY);
    run_stream(1'b0, 3);

    // All-ff key after returning to IDLE.
    set_partial('1, 128'he8e9e9e917161616e8e9e9e917161616, '0, 1'b0);
    load_key('1);
    run_stream(1'b0, -1);

    // All-zero key.
    set_partial('0, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1);
    load_key('0);
    run_stream(1'b0, -1);

    // FIPS key under random backpressure.
    set_fips();
    load_key(FIPS_KEY);
    run_stream(1'b1, -1);

    // Reset mid-stream at round 4, then a clean FIPS run.
    load_key(FIPS_KEY);
    round_key_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    round_key_ready = 1'b0;
    check("pre-rst idx", round_idx, 4);
    check("pre-rst key", round_key, FIPS_RK[4]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-rst valid", round_key_valid, 0);
    check("mid-rst idx", round_idx, 0);
    check("mid-rst key_ready", key_ready, 1);
    check("mid-rst round_key", round_key, 0);
    check("mid-rst last", last_key, 0);
    load_key(FIPS_KEY);
    run_stream(1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
